pc_sequencer: RTL and testbench

- Program-counter and fetch sequencer sitting directly upstream of the instruction memory; drives its 4-bit read address every cycle.
- Supports sequential increment, absolute jump, relative conditional branch, call/return through a small return-address stack, stall, and halt/resume.
- Control inputs come from the decode/control stage that consumes the instruction memory's Control/Word fields.

---
 rtl/pc_seq_pkg.sv | 48 ++++
 rtl/pc_return_stack.sv | 62 ++++++
 rtl/pc_sequencer.sv | 142 ++++++++++++++
 tb/tb_pc_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  localparam int unsigned ADDR_W_DEF  = 4;
  localparam int unsigned STACK_D_DEF = 4;

  // Sequencer control state.
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Winning request in RUN, highest priority first.
  typedef enum logic [2:0] {
    REQ_HALT   = 3'd0,
    REQ_STALL  = 3'd1,
    REQ_RET    = 3'd2,
    REQ_CALL   = 3'd3,
    REQ_JUMP   = 3'd4,
    REQ_BRANCH = 3'd5,
    REQ_INC    = 3'd6
  } req_e;

  // Resolve simultaneous requests to the single one that acts this edge.
  function automatic req_e pick_req(input logic halt, input logic stall,
                                    input logic ret, input logic call,
                                    input logic jump, input logic br_taken);
    req_e r;
    if (halt) begin
      r = REQ_HALT;
    end else if (stall) begin
      r = REQ_STALL;
    end else if (ret) begin
      r = REQ_RET;
    end else if (call) begin
      r = REQ_CALL;
    end else if (jump) begin
      r = REQ_JUMP;
    end else if (br_taken) begin
      r = REQ_BRANCH;
    end else begin
      r = REQ_INC;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO. The parent never pushes and pops together and never
// pushes when full or pops when empty; the guards below only keep the
// pointer in range should that ever be violated.
module pc_return_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned STACK_D = STACK_D_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] din_i,
  output logic [ADDR_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned IDX_W = $clog2(STACK_D);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [ADDR_W-1:0] mem_q [STACK_D];
  logic [PTR_W-1:0]  sp_q;
  logic [PTR_W-1:0]  sp_d;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [IDX_W-1:0]  top_idx_s;

  assign wr_idx_s  = sp_q[IDX_W-1:0];
  assign top_idx_s = wr_idx_s - IDX_W'(1);
  assign full_o    = (sp_q == PTR_W'(STACK_D));
  assign empty_o   = (sp_q == PTR_W'(0));
  assign dout_o    = mem_q[top_idx_s];

  // Next stack pointer from the push/pop request.
  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + PTR_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - PTR_W'(1);
    end else begin
      sp_d = sp_q;
    end
  end

  // Pointer and entry storage; reset discards all contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_q <= PTR_W'(0);
      for (int i = 0; i < int'(STACK_D); i++) begin
        mem_q[i] <= ADDR_W'(0);
      end
    end else begin
      sp_q <= sp_d;
      if (push_i && !full_o) begin
        mem_q[wr_idx_s] <= din_i;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter / fetch sequencer driving the instruction-memory address.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned STACK_D    = STACK_D_DEF,
  parameter bit          WRAP       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] ReadAdd,
  output logic              FetchValid,
  input  logic              Stall,
  input  logic              JumpEn,
  input  logic [ADDR_W-1:0] JumpTarget,
  input  logic              BranchEn,
  input  logic              BranchCond,
  input  logic [ADDR_W-1:0] BranchOff,
  input  logic              CallEn,
  input  logic              RetEn,
  input  logic              Halt,
  input  logic              Resume,
  output logic              Halted,
  output logic              StackErr
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fv_q, fv_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;
  logic              push_s, pop_s;
  logic [ADDR_W-1:0] stk_dout_s;
  logic              stk_full_s, stk_empty_s;
  logic [ADDR_W-1:0] pc_inc_s, pc_br_s;
  logic              inc_halts_s;
  req_e              req_s;

  // Modulo arithmetic wraps naturally; the offset is two's complement.
  assign pc_inc_s    = pc_q + ADDR_W'(1);
  assign pc_br_s     = pc_q + BranchOff;
  assign inc_halts_s = !WRAP && (pc_q == {ADDR_W{1'b1}});
  assign req_s       = pick_req(Halt, Stall, RetEn, CallEn, JumpEn, BranchEn && BranchCond);

  pc_return_stack #(
    .ADDR_W  (ADDR_W),
    .STACK_D (STACK_D)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (pc_inc_s),
    .dout_o  (stk_dout_s),
    .full_o  (stk_full_s),
    .empty_o (stk_empty_s)
  );

  // Next state, next PC, stack commands and next output values.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    case (state_q)
      ST_START: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        case (req_s)
          REQ_HALT:  state_d = ST_HALT;
          REQ_STALL: pc_d = pc_q;
          REQ_RET: begin
            if (stk_empty_s) begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              pc_d  = stk_dout_s;
              pop_s = 1'b1;
            end
          end
          REQ_CALL: begin
            if (stk_full_s) begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              pc_d   = JumpTarget;
              push_s = 1'b1;
            end
          end
          REQ_JUMP:   pc_d = JumpTarget;
          REQ_BRANCH: pc_d = pc_br_s;
          REQ_INC: begin
            if (inc_halts_s) begin
              state_d = ST_HALT;
            end else begin
              pc_d = pc_inc_s;
            end
          end
          default: state_d = ST_HALT;
        endcase
      end
      ST_HALT: begin
        // A stack error can only be cleared by reset, so Resume is ignored.
        if (Resume && !Halt && !err_q && !inc_halts_s) begin
          state_d = ST_RUN;
          pc_d    = pc_inc_s;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_START;
    endcase
    fv_d     = (state_d == ST_RUN);
    halted_d = (state_d == ST_HALT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_START;
      pc_q     <= ADDR_W'(RESET_ADDR);
      fv_q     <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fv_q     <= fv_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign ReadAdd    = pc_q;
  assign FetchValid = fv_q;
  assign Halted     = halted_q;
  assign StackErr   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// stimulus, all compared every cycle against a queue-based reference model.
module tb_pc_sequencer;

  localparam int MS_START = 0;
  localparam int MS_RUN   = 1;
  localparam int MS_HALT  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ReadAdd;
  logic       FetchValid, Stall, JumpEn, BranchEn, BranchCond, CallEn, RetEn;
  logic       Halt, Resume, Halted, StackErr;
  logic [3:0] JumpTarget, BranchOff;

  logic       rst_nw;
  logic [3:0] ra_nw;
  logic       fv_nw, halted_nw, err_nw;

  int n_checks = 0;
  int n_fail   = 0;

  int m_pc;
  int m_state;
  int m_stk[$];
  bit m_err;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(4), .RESET_ADDR(0), .STACK_D(4), .WRAP(1'b1)) u_dut (
    .clk(clk), .rst(rst), .ReadAdd(ReadAdd), .FetchValid(FetchValid),
    .Stall(Stall), .JumpEn(JumpEn), .JumpTarget(JumpTarget),
    .BranchEn(BranchEn), .BranchCond(BranchCond), .BranchOff(BranchOff),
    .CallEn(CallEn), .RetEn(RetEn), .Halt(Halt), .Resume(Resume),
    .Halted(Halted), .StackErr(StackErr)
  );

  pc_sequencer #(.ADDR_W(4), .RESET_ADDR(0), .STACK_D(4), .WRAP(1'b0)) u_dut_nw (
    .clk(clk), .rst(rst_nw), .ReadAdd(ra_nw), .FetchValid(fv_nw),
    .Stall(1'b0), .JumpEn(1'b0), .JumpTarget(4'd0),
    .BranchEn(1'b0), .BranchCond(1'b0), .BranchOff(4'd0),
    .CallEn(1'b0), .RetEn(1'b0), .Halt(1'b0), .Resume(1'b0),
    .Halted(halted_nw), .StackErr(err_nw)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one rising edge with the current inputs.
  task automatic model_step();
    if (rst === 1'b0) begin
      m_pc = 0; m_state = MS_START; m_stk.delete(); m_err = 1'b0;
    end else if (m_state == MS_START) begin
      m_state = MS_RUN;
    end else if (m_state == MS_RUN) begin
      if (Halt) m_state = MS_HALT;
      else if (Stall) m_pc = m_pc;
      else if (RetEn) begin
        if (m_stk.size() == 0) begin m_err = 1'b1; m_state = MS_HALT; end
        else m_pc = m_stk.pop_back();
      end else if (CallEn) begin
        if (m_stk.size() == 4) begin m_err = 1'b1; m_state = MS_HALT; end
        else begin m_stk.push_back((m_pc + 1) % 16); m_pc = int'(JumpTarget); end
      end else if (JumpEn) m_pc = int'(JumpTarget);
      else if (BranchEn && BranchCond) m_pc = (m_pc + int'($signed(BranchOff))) & 15;
      else m_pc = (m_pc + 1) % 16;
    end else begin
      if (Resume && !Halt && !m_err) begin m_state = MS_RUN; m_pc = (m_pc + 1) % 16; end
    end
  endtask

  // One clock: advance the model on the edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("ReadAdd", 32'(ReadAdd), 32'(m_pc));
    check("FetchValid", 32'(FetchValid), 32'(m_state == MS_RUN));
    check("Halted", 32'(Halted), 32'(m_state == MS_HALT));
    check("StackErr", 32'(StackErr), 32'(m_err));
  endtask

  task automatic clear_req();
    Stall = 1'b0; JumpEn = 1'b0; BranchEn = 1'b0; BranchCond = 1'b0;
    CallEn = 1'b0; RetEn = 1'b0; Halt = 1'b0; Resume = 1'b0;
    JumpTarget = 4'd0; BranchOff = 4'd0;
  endtask

  task automatic run_to(input logic [3:0] t);
    clear_req();
    for (int k = 0; k < 40 && ReadAdd !== t; k++) tick();
    check("run_to_reached", 32'(ReadAdd), 32'(t));
  endtask

  task automatic do_reset();
    rst = 1'b0; clear_req();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0; rst_nw = 1'b0; clear_req();
    m_pc = 0; m_state = MS_START; m_err = 1'b0;

    // Reset values, then free run with wrap.
    tick(); tick();
    check("rst_ra", 32'(ReadAdd), 32'd0);
    check("rst_fv", 32'(FetchValid), 32'd0);
    check("rst_halted", 32'(Halted), 32'd0);
    check("rst_err", 32'(StackErr), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("freerun_ra", 32'(ReadAdd), 32'(i % 16));
      check("freerun_fv", 32'(FetchValid), 32'd1);
    end

    // Jump then backward branch: 3,9,7,8.
    check("pre_jump_ra", 32'(ReadAdd), 32'd3);
    JumpEn = 1'b1; JumpTarget = 4'd9;
    tick(); check("jump_ra", 32'(ReadAdd), 32'd9);
    JumpEn = 1'b0; BranchEn = 1'b1; BranchCond = 1'b1; BranchOff = 4'b1110;
    tick(); check("branch_ra", 32'(ReadAdd), 32'd7);
    clear_req();
    tick(); check("post_branch_ra", 32'(ReadAdd), 32'd8);

    // Stall beats a held jump, then the jump lands.
    run_to(4'd5);
    Stall = 1'b1; JumpEn = 1'b1; JumpTarget = 4'd10;
    repeat (3) begin tick(); check("stall_ra", 32'(ReadAdd), 32'd5); end
    Stall = 1'b0;
    tick(); check("unstall_jump_ra", 32'(ReadAdd), 32'd10);

    // Call and return: 2,12,13,3.
    run_to(4'd2);
    CallEn = 1'b1; JumpTarget = 4'd12;
    tick(); check("call_ra", 32'(ReadAdd), 32'd12);
    CallEn = 1'b0;
    tick(); check("callee_ra", 32'(ReadAdd), 32'd13);
    RetEn = 1'b1;
    tick(); check("ret_ra", 32'(ReadAdd), 32'd3);
    clear_req();

    // Five nested calls overflow a four-deep stack.
    CallEn = 1'b1; JumpTarget = 4'd8;
    repeat (5) tick();
    check("ovf_err", 32'(StackErr), 32'd1);
    check("ovf_halted", 32'(Halted), 32'd1);
    check("ovf_fv", 32'(FetchValid), 32'd0);
    clear_req(); Resume = 1'b1;
    repeat (3) tick();
    check("ovf_resume_ignored", 32'(Halted), 32'd1);
    do_reset();
    check("ovf_cleared", 32'(StackErr), 32'd0);

    // Return on empty stack.
    RetEn = 1'b1;
    tick(); check("udf_err", 32'(StackErr), 32'd1);
    do_reset();

    // Halt, Halt+Resume together, then Resume.
    run_to(4'd6);
    Halt = 1'b1;
    tick();
    check("halt_halted", 32'(Halted), 32'd1);
    check("halt_fv", 32'(FetchValid), 32'd0);
    check("halt_ra", 32'(ReadAdd), 32'd6);
    Resume = 1'b1;
    tick(); check("halt_resume_both", 32'(Halted), 32'd1);
    Halt = 1'b0;
    tick();
    check("resume_ra", 32'(ReadAdd), 32'd7);
    check("resume_fv", 32'(FetchValid), 32'd1);
    clear_req();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 149) != 0);
      Stall      = ($urandom_range(0, 7) == 0);
      Halt       = ($urandom_range(0, 39) == 0);
      Resume     = ($urandom_range(0, 3) == 0);
      RetEn      = ($urandom_range(0, 9) == 0);
      CallEn     = ($urandom_range(0, 7) == 0);
      JumpEn     = ($urandom_range(0, 7) == 0);
      BranchEn   = ($urandom_range(0, 5) == 0);
      BranchCond = 1'($urandom_range(0, 1));
      BranchOff  = 4'($urandom_range(0, 15));
      JumpTarget = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b1; clear_req();

    // No-wrap instance: runs to 15 then halts; reset recovers.
    rst_nw = 1'b1;
    repeat (16) @(negedge clk);
    check("nw_ra_15", 32'(ra_nw), 32'd15);
    check("nw_running", 32'(halted_nw), 32'd0);
    @(negedge clk);
    check("nw_halted", 32'(halted_nw), 32'd1);
    check("nw_hold_ra", 32'(ra_nw), 32'd15);
    check("nw_fv", 32'(fv_nw), 32'd0);
    repeat (3) @(negedge clk);
    check("nw_still_ra", 32'(ra_nw), 32'd15);
    rst_nw = 1'b0;
    @(negedge clk);
    check("nw_rst_ra", 32'(ra_nw), 32'd0);
    check("nw_rst_halted", 32'(halted_nw), 32'd0);
    check("nw_rst_err", 32'(err_nw), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
